mem_port_arbiter: RTL

Two-requester arbiter in front of the single-read/single-write data memory of the RISC-V monocycle system. It shares the memory between the core's load/store port (requester 0) and the IO-interface port (requester 1), used for host program load and peripheral buffers. Arbitration is round-robin with an IO burst-lock mode. Read data returns through a registered path with `rvalid`.

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter_rr_arb2.sv | 36 +++
 rtl/mem_port_arbiter.sv | 94 +++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the data-memory port arbiter: FSM state encoding
// and requester indices used by the top level and the round-robin core.
package mem_arb_pkg;

  localparam logic ARB_S  = 1'b0;
  localparam logic LOCK_S = 1'b1;

  localparam int REQ_CORE = 0;
  localparam int REQ_IO   = 1;

  typedef enum logic {
    ST_ARB  = ARB_S,
    ST_LOCK = LOCK_S
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle of the memory port arbiter: core load/store port,
// IO-interface port and their grant / read-return responses.
interface mem_port_arbiter_if #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 32
);

  logic             core_req_i;
  logic             core_we_i;
  logic [DEPTH-1:0] core_addr_i;
  logic [WIDTH-1:0] core_wdata_i;
  logic             io_req_i;
  logic             io_we_i;
  logic [DEPTH-1:0] io_addr_i;
  logic [WIDTH-1:0] io_wdata_i;
  logic             io_lock_i;

  logic             core_gnt_o;
  logic             io_gnt_o;
  logic             core_rvalid_o;
  logic             io_rvalid_o;
  logic [WIDTH-1:0] core_rdata_o;
  logic [WIDTH-1:0] io_rdata_o;
  logic             core_stall_o;

  modport master (
    output core_req_i, core_we_i, core_addr_i, core_wdata_i,
    output io_req_i, io_we_i, io_addr_i, io_wdata_i, io_lock_i,
    input  core_gnt_o, io_gnt_o, core_rvalid_o, io_rvalid_o,
    input  core_rdata_o, io_rdata_o, core_stall_o
  );

  modport slave (
    input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
    input  io_req_i, io_we_i, io_addr_i, io_wdata_i, io_lock_i,
    output core_gnt_o, io_gnt_o, core_rvalid_o, io_rvalid_o,
    output core_rdata_o, io_rdata_o, core_stall_o
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin grant: a tie goes to the requester not granted most
// recently; hold restricts the grant to the IO requester.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] gnt
);

  logic last_q;  // index of the requester granted most recently

  // NOTE: every output of an always_comb gets a default first so no path
  // through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    gnt = '0;
    if (hold) begin
      gnt[REQ_IO] = req[REQ_IO];
    end else if (req[REQ_CORE] && req[REQ_IO]) begin
      if (last_q == 1'(REQ_IO)) gnt[REQ_CORE] = 1'b1;
      else                      gnt[REQ_IO]   = 1'b1;
    end else begin
      gnt = req;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_q <= 1'(REQ_IO);
    else if (|gnt) last_q <= gnt[REQ_IO];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-read/single-write data memory between the core and the
// IO interface, with an IO burst-lock mode and a registered read return.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  mem_port_arbiter_if.slave   bus,
  output logic                mem_re_o,
  output logic [DEPTH-1:0]    mem_addread_o,
  input  logic [WIDTH-1:0]    mem_data_i,
  output logic                mem_we_o,
  output logic [DEPTH-1:0]    mem_addwrite_o,
  output logic [WIDTH-1:0]    mem_data_o
);

  state_e           state_q;
  logic [1:0]       req;
  logic [1:0]       gnt;
  logic             hold;
  logic             sel_we;
  logic [DEPTH-1:0] sel_addr;
  logic [WIDTH-1:0] sel_data;

  // Requests are masked by the reset level so nothing is granted, and no
  // memory enable can rise, while reset is asserted.
  assign req  = {bus.io_req_i & rst_ni, bus.core_req_i & rst_ni};
  assign hold = (state_q == ST_LOCK) && bus.io_lock_i;

  rr_arb2 u_rr_arb2 (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .req   (req),
    .hold  (hold),
    .gnt   (gnt)
  );

  assign bus.core_gnt_o   = gnt[REQ_CORE];
  assign bus.io_gnt_o     = gnt[REQ_IO];
  assign bus.core_stall_o = bus.core_req_i & ~gnt[REQ_CORE];

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    if (gnt[REQ_CORE]) begin
      sel_we   = bus.core_we_i;
      sel_addr = bus.core_addr_i;
      sel_data = bus.core_wdata_i;
    end else if (gnt[REQ_IO]) begin
      sel_we   = bus.io_we_i;
      sel_addr = bus.io_addr_i;
      sel_data = bus.io_wdata_i;
    end
  end

  assign mem_re_o       = (|gnt) & ~sel_we;
  assign mem_we_o       = (|gnt) &  sel_we;
  assign mem_addread_o  = sel_addr;
  assign mem_addwrite_o = sel_addr;
  assign mem_data_o     = sel_data;

  // The lock is released on the first cycle io_lock_i drops; that cycle is
  // already arbitrated round-robin because hold is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_ARB;
    end else begin
      case (state_q)
        ST_ARB:  if (gnt[REQ_IO] && bus.io_lock_i) state_q <= ST_LOCK;
        ST_LOCK: if (!bus.io_lock_i)               state_q <= ST_ARB;
        default:                                   state_q <= ST_ARB;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.core_rvalid_o <= 1'b0;
      bus.io_rvalid_o   <= 1'b0;
      bus.core_rdata_o  <= '0;
      bus.io_rdata_o    <= '0;
    end else begin
      bus.core_rvalid_o <= gnt[REQ_CORE] & ~bus.core_we_i;
      bus.io_rvalid_o   <= gnt[REQ_IO]   & ~bus.io_we_i;
      if (gnt[REQ_CORE] && !bus.core_we_i) bus.core_rdata_o <= mem_data_i;
      if (gnt[REQ_IO]   && !bus.io_we_i)   bus.io_rdata_o   <= mem_data_i;
    end
  end

endmodule
